// File: rtl/quadrilatero_xif_issue_buffer.sv
// -----------------------------------------------------------------------------
// quadrilatero_xif_issue_buffer
//
// Purpose:
//   Sits between the core's XIF issue/commit interface and the matrix dispatch
//   logic. Each issued word is sent straight to the combinational XIF decoder
//   and its accept bit is returned to the core. Accepted instructions and their
//   operands go into an in-order FIFO. Each entry waits there for its commit or
//   kill. It is then dispatched in order, or dropped.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   x_issue_*                 XIF issue request (valid/ready, word, id, rs1/rs2)
//   x_issue_accept_o          decoder accept bit returned to the core
//   dec_instr_o/dec_accept_i  combinational decoder hook
//   x_commit_*                XIF commit event (id, kill)
//   disp_*                    head-of-FIFO dispatch handshake and payload
//   empty_o                   no entries held
//   unmatched_commit_o        one-cycle pulse, the cycle after a commit that
//                             matched no pending entry
// -----------------------------------------------------------------------------
module quadrilatero_xif_issue_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned X_RFR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,

    // issue interface
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  logic [31:0]        x_issue_instr_i,
    input  logic [ID_W-1:0]    x_issue_id_i,
    input  logic [X_RFR_W-1:0] x_issue_rs1_i,
    input  logic [X_RFR_W-1:0] x_issue_rs2_i,
    input  logic [1:0]         x_issue_rs_valid_i,
    output logic               x_issue_accept_o,

    // decoder hook
    output logic [31:0]        dec_instr_o,
    input  logic               dec_accept_i,

    // commit interface
    input  logic               x_commit_valid_i,
    input  logic [ID_W-1:0]    x_commit_id_i,
    input  logic               x_commit_kill_i,

    // dispatch interface
    output logic               disp_valid_o,
    input  logic               disp_ready_i,
    output logic [31:0]        disp_instr_o,
    output logic [X_RFR_W-1:0] disp_rs1_o,
    output logic [X_RFR_W-1:0] disp_rs2_o,
    output logic [ID_W-1:0]    disp_id_o,

    // status
    output logic               empty_o,
    output logic               unmatched_commit_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_INVALID   = 2'd0,
        ST_PENDING   = 2'd1,
        ST_COMMITTED = 2'd2,
        ST_KILLED    = 2'd3
    } entry_state_e;

    typedef struct packed {
        logic [31:0]        instr;
        logic [ID_W-1:0]    id;
        logic [X_RFR_W-1:0] rs1;
        logic [X_RFR_W-1:0] rs2;
    } entry_t;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    entry_t           data_q  [DEPTH];
    entry_state_e     state_q [DEPTH];
    entry_state_e     state_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             unmatched_q, unmatched_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic         full;
    logic         issue_hs;
    logic         enq;
    logic         enq_commit;
    logic         pop;
    logic         match_any;
    logic         pending_dup;
    entry_state_e head_state;
    entry_state_e resolved_state;

    // Ready depends on registered fullness only. A pop in the same cycle
    // therefore does not reopen the issue port until the next cycle.
    assign full            = (count_q == CNT_W'(DEPTH));
    assign x_issue_ready_o = !rst_i && !full && (x_issue_rs_valid_i == 2'b11);
    assign issue_hs        = x_issue_valid_i && x_issue_ready_o;
    assign enq             = issue_hs && dec_accept_i;

    assign x_issue_accept_o = dec_accept_i;
    assign dec_instr_o      = x_issue_instr_i;

    // A commit that names the instruction being enqueued right now resolves it
    // at write time. The entry never sits in PENDING.
    assign enq_commit     = enq && x_commit_valid_i && (x_commit_id_i == x_issue_id_i);
    assign resolved_state = x_commit_kill_i ? ST_KILLED : ST_COMMITTED;

    // Only the head may leave. A PENDING head blocks everything behind it.
    // A KILLED head drains by itself without showing on the dispatch port.
    assign head_state   = state_q[rd_ptr_q];
    assign disp_valid_o = (head_state == ST_COMMITTED);
    assign pop          = (disp_valid_o && disp_ready_i) || (head_state == ST_KILLED);

    assign disp_instr_o = data_q[rd_ptr_q].instr;
    assign disp_id_o    = data_q[rd_ptr_q].id;
    assign disp_rs1_o   = data_q[rd_ptr_q].rs1;
    assign disp_rs2_o   = data_q[rd_ptr_q].rs2;

    assign empty_o            = (count_q == '0);
    assign unmatched_commit_o = unmatched_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_d     = state_q;
        match_any   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        unmatched_d = 1'b0;

        // Commit/kill resolves every pending entry carrying the committed id.
        if (x_commit_valid_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (state_q[PTR_W'(i)] == ST_PENDING &&
                    data_q[PTR_W'(i)].id == x_commit_id_i) begin
                    state_d[PTR_W'(i)] = resolved_state;
                    match_any          = 1'b1;
                end
            end
        end

        // The popped slot is COMMITTED or KILLED, so the commit loop above
        // never touches it. The write slot is free because the FIFO is not full.
        if (pop) begin
            state_d[rd_ptr_q] = ST_INVALID;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        if (enq) begin
            state_d[wr_ptr_q] = enq_commit ? resolved_state : ST_PENDING;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        unique case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        unmatched_d = x_commit_valid_i && !match_any && !enq_commit;
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge value, whatever order the blocks run in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[PTR_W'(i)] <= ST_INVALID;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            unmatched_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[PTR_W'(i)] <= state_d[PTR_W'(i)];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            unmatched_q <= unmatched_d;
        end
    end

    // -------------------------------------------------------------------------
    // Payload storage
    // -------------------------------------------------------------------------
    // NOTE: the payload array has no reset. An entry only means something
    // while its state is not ST_INVALID, and the state array is reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            data_q[wr_ptr_q] <= '{instr: x_issue_instr_i,
                                  id:    x_issue_id_i,
                                  rs1:   x_issue_rs1_i,
                                  rs2:   x_issue_rs2_i};
        end
    end

    // -------------------------------------------------------------------------
    // Protocol check: an accepted id must not already be pending.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_dup = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (state_q[PTR_W'(i)] == ST_PENDING &&
                data_q[PTR_W'(i)].id == x_issue_id_i) begin
                pending_dup = 1'b1;
            end
        end
    end

    a_unique_pending_id : assert property (
        @(posedge clk_i) disable iff (rst_i) enq |-> !pending_dup
    ) else $error("issue buffer: accepted id already pending");

endmodule

// File: tb/tb_quadrilatero_xif_issue_buffer.sv
module tb_quadrilatero_xif_issue_buffer;

    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int X_RFR_W = 32;

    localparam int ST_P = 0;   // waiting for commit
    localparam int ST_C = 1;   // committed, may dispatch
    localparam int ST_K = 2;   // killed, will be dropped

    localparam logic [31:0] MLD_W_WORD = 32'h0c05_a0ab;

    typedef struct {
        logic [31:0]        instr;
        logic [ID_W-1:0]    id;
        logic [X_RFR_W-1:0] rs1;
        logic [X_RFR_W-1:0] rs2;
        int                 st;
    } mentry_t;

    // model: the FIFO as an in-order queue of entries
    mentry_t         mq[$];
    logic            exp_unmatched;
    logic [ID_W-1:0] disp_log[$];

    int n_tests;
    int n_fail;

    // DUT signals
    logic               clk;
    logic               rst;
    logic               x_issue_valid;
    logic               x_issue_ready;
    logic [31:0]        x_issue_instr;
    logic [ID_W-1:0]    x_issue_id;
    logic [X_RFR_W-1:0] x_issue_rs1;
    logic [X_RFR_W-1:0] x_issue_rs2;
    logic [1:0]         x_issue_rs_valid;
    logic               x_issue_accept;
    logic [31:0]        dec_instr;
    logic               dec_accept;
    logic               x_commit_valid;
    logic [ID_W-1:0]    x_commit_id;
    logic               x_commit_kill;
    logic               disp_valid;
    logic               disp_ready;
    logic [31:0]        disp_instr;
    logic [X_RFR_W-1:0] disp_rs1;
    logic [X_RFR_W-1:0] disp_rs2;
    logic [ID_W-1:0]    disp_id;
    logic               empty;
    logic               unmatched;

    quadrilatero_xif_issue_buffer #(
        .DEPTH   (DEPTH),
        .ID_W    (ID_W),
        .X_RFR_W (X_RFR_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .x_issue_valid_i    (x_issue_valid),
        .x_issue_ready_o    (x_issue_ready),
        .x_issue_instr_i    (x_issue_instr),
        .x_issue_id_i       (x_issue_id),
        .x_issue_rs1_i      (x_issue_rs1),
        .x_issue_rs2_i      (x_issue_rs2),
        .x_issue_rs_valid_i (x_issue_rs_valid),
        .x_issue_accept_o   (x_issue_accept),
        .dec_instr_o        (dec_instr),
        .dec_accept_i       (dec_accept),
        .x_commit_valid_i   (x_commit_valid),
        .x_commit_id_i      (x_commit_id),
        .x_commit_kill_i    (x_commit_kill),
        .disp_valid_o       (disp_valid),
        .disp_ready_i       (disp_ready),
        .disp_instr_o       (disp_instr),
        .disp_rs1_o         (disp_rs1),
        .disp_rs2_o         (disp_rs2),
        .disp_id_o          (disp_id),
        .empty_o            (empty),
        .unmatched_commit_o (unmatched)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pending_has(input logic [ID_W-1:0] id);
        foreach (mq[i]) if (mq[i].st == ST_P && mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        x_issue_valid    = 1'b0;
        x_issue_instr    = $urandom;
        x_issue_id       = '0;
        x_issue_rs1      = $urandom;
        x_issue_rs2      = $urandom;
        x_issue_rs_valid = 2'b11;
        dec_accept       = 1'b0;
        x_commit_valid   = 1'b0;
        x_commit_id      = '0;
        x_commit_kill    = 1'b0;
        disp_ready       = 1'b0;
    endtask

    task automatic issue(input logic [ID_W-1:0] id, input logic [31:0] instr,
                         input logic acc);
        x_issue_valid = 1'b1;
        x_issue_id    = id;
        x_issue_instr = instr;
        x_issue_rs1   = $urandom;
        x_issue_rs2   = $urandom;
        dec_accept    = acc;
    endtask

    task automatic commit(input logic [ID_W-1:0] id, input logic kill);
        x_commit_valid = 1'b1;
        x_commit_id    = id;
        x_commit_kill  = kill;
    endtask

    // Called at a negedge with the inputs for this cycle applied. It compares
    // the outputs against the model just before the posedge, advances the
    // model by one clock, and returns at the following negedge.
    task automatic cycle();
        logic    exp_ready;
        logic    exp_dv;
        bit      enq;
        bit      pop;
        bit      matched;
        mentry_t e;

        #3;
        exp_ready = (mq.size() < DEPTH) && (x_issue_rs_valid == 2'b11);
        exp_dv    = (mq.size() > 0) && (mq[0].st == ST_C);

        check("issue_ready", x_issue_ready, exp_ready);
        if (x_issue_valid) check("issue_accept", x_issue_accept, dec_accept);
        check("dec_instr", dec_instr, x_issue_instr);
        check("empty", empty, mq.size() == 0);
        check("disp_valid", disp_valid, exp_dv);
        check("unmatched_commit", unmatched, exp_unmatched);
        if (exp_dv) begin
            check("disp_id", disp_id, mq[0].id);
            check("disp_instr", disp_instr, mq[0].instr);
            check("disp_rs1", disp_rs1, mq[0].rs1);
            check("disp_rs2", disp_rs2, mq[0].rs2);
        end
        if (disp_valid && disp_ready) disp_log.push_back(disp_id);

        // model step
        enq     = x_issue_valid && exp_ready && dec_accept;
        pop     = (mq.size() > 0) &&
                  ((mq[0].st == ST_C && disp_ready) || mq[0].st == ST_K);
        matched = 1'b0;
        if (x_commit_valid) begin
            foreach (mq[i]) begin
                if (mq[i].st == ST_P && mq[i].id == x_commit_id) begin
                    mq[i].st = x_commit_kill ? ST_K : ST_C;
                    matched  = 1'b1;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (enq) begin
            e.instr = x_issue_instr;
            e.id    = x_issue_id;
            e.rs1   = x_issue_rs1;
            e.rs2   = x_issue_rs2;
            e.st    = ST_P;
            if (x_commit_valid && x_commit_id == x_issue_id) begin
                e.st    = x_commit_kill ? ST_K : ST_C;
                matched = 1'b1;
            end
            mq.push_back(e);
        end
        exp_unmatched = x_commit_valid && !matched;

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [ID_W-1:0]    rid;
        logic [X_RFR_W-1:0] s1_rs1;
        logic [X_RFR_W-1:0] s1_rs2;
        int                 k;

        n_tests       = 0;
        n_fail        = 0;
        exp_unmatched = 1'b0;
        rst           = 1'b1;
        idle();
        x_issue_valid = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_ready_low", x_issue_ready, 1'b0);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_unmatched", unmatched, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        cycle();

        // ---------------- issue, commit two cycles later ----------------
        issue(4'd3, MLD_W_WORD, 1'b1);
        s1_rs1 = 32'h0000_1000;
        s1_rs2 = 32'h0000_0040;
        x_issue_rs1 = s1_rs1;
        x_issue_rs2 = s1_rs2;
        #1;
        check("s1_accept", x_issue_accept, 1'b1);
        check("s1_ready", x_issue_ready, 1'b1);
        cycle();
        idle();
        cycle();
        commit(4'd3, 1'b0);
        check("s1_not_yet_valid", disp_valid, 1'b0);
        cycle();
        check("s1_disp_valid", disp_valid, 1'b1);
        check("s1_disp_id", disp_id, 4'd3);
        check("s1_disp_instr", disp_instr, MLD_W_WORD);
        check("s1_disp_rs1", disp_rs1, 32'h0000_1000);
        check("s1_disp_rs2", disp_rs2, 32'h0000_0040);
        idle();
        disp_ready = 1'b1;
        cycle();
        idle();
        check("s1_empty_after", empty, 1'b1);

        // ---------------- rejected word ----------------
        issue(4'd7, 32'hffff_ffff, 1'b0);
        #1;
        check("s2_accept_low", x_issue_accept, 1'b0);
        check("s2_ready", x_issue_ready, 1'b1);
        cycle();
        idle();
        check("s2_still_empty", empty, 1'b1);
        commit(4'd7, 1'b0);
        cycle();
        idle();
        check("s2_unmatched_pulse", unmatched, 1'b1);
        cycle();
        check("s2_unmatched_drop", unmatched, 1'b0);

        // ---------------- kill in the middle ----------------
        disp_log.delete();
        for (int i = 1; i <= 3; i++) begin
            idle();
            issue(ID_W'(i), 32'h1000_0000 + i, 1'b1);
            cycle();
        end
        idle(); disp_ready = 1'b1; commit(4'd2, 1'b1); cycle();
        idle(); disp_ready = 1'b1; commit(4'd1, 1'b0); cycle();
        idle(); disp_ready = 1'b1; commit(4'd3, 1'b0); cycle();
        idle(); disp_ready = 1'b1;
        repeat (4) cycle();
        check("s3_disp_count", disp_log.size(), 2);
        if (disp_log.size() == 2) begin
            check("s3_first_id", disp_log[0], 4'd1);
            check("s3_second_id", disp_log[1], 4'd3);
        end
        check("s3_empty", empty, 1'b1);

        // ---------------- fill to full ----------------
        for (int i = 8; i <= 11; i++) begin
            idle();
            issue(ID_W'(i), 32'h2000_0000 + i, 1'b1);
            cycle();
        end
        idle();
        check("s4_full_ready_low", x_issue_ready, 1'b0);
        issue(4'd12, 32'h2000_000c, 1'b1);
        cycle();
        check("s4_fifth_stalled", x_issue_ready, 1'b0);
        check("s4_not_empty", empty, 1'b0);
        idle(); commit(4'd8, 1'b0); cycle();
        idle(); disp_ready = 1'b1; cycle();
        idle();
        check("s4_ready_back", x_issue_ready, 1'b1);
        for (int i = 9; i <= 11; i++) begin
            idle();
            commit(ID_W'(i), 1'b1);
            cycle();
        end
        idle();
        repeat (4) cycle();
        check("s4_drained", empty, 1'b1);

        // ---------------- same-cycle commit on empty FIFO ----------------
        issue(4'd5, 32'h3000_0005, 1'b1);
        commit(4'd5, 1'b0);
        cycle();
        idle();
        check("s5_disp_valid", disp_valid, 1'b1);
        check("s5_disp_id", disp_id, 4'd5);
        check("s5_no_unmatched", unmatched, 1'b0);
        disp_ready = 1'b1;
        cycle();
        idle();
        cycle();
        check("s5_empty", empty, 1'b1);

        // ---------------- async reset with committed entries ----------------
        issue(4'd1, 32'h4000_0001, 1'b1); commit(4'd1, 1'b0); cycle();
        idle();
        issue(4'd2, 32'h4000_0002, 1'b1); commit(4'd2, 1'b0); cycle();
        idle();
        check("s6_pre_valid", disp_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_disp_valid", disp_valid, 1'b0);
        check("s6_async_empty", empty, 1'b1);
        check("s6_async_ready", x_issue_ready, 1'b0);
        mq.delete();
        exp_unmatched = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        disp_ready = 1'b1;
        disp_log.delete();
        repeat (3) cycle();
        check("s6_nothing_dispatched", disp_log.size(), 0);
        check("s6_empty_after", empty, 1'b1);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 2000; c++) begin
            idle();
            if ($urandom_range(2, 0) != 0) begin
                do rid = ID_W'($urandom); while (pending_has(rid));
                issue(rid, $urandom, ($urandom_range(4, 0) != 0));
            end
            if ($urandom_range(3, 0) == 0) x_issue_rs_valid = 2'($urandom);
            if ($urandom_range(1, 0) == 0) begin
                k = $urandom_range(5, 0);
                if (k == 0 && x_issue_valid) begin
                    commit(x_issue_id, ($urandom_range(2, 0) == 0));
                end else if (k <= 3 && mq.size() > 0) begin
                    commit(mq[$urandom_range(mq.size() - 1, 0)].id,
                           ($urandom_range(2, 0) == 0));
                end else begin
                    commit(ID_W'($urandom), ($urandom_range(2, 0) == 0));
                end
            end
            disp_ready = ($urandom_range(3, 0) != 0);
            cycle();
        end

        // drain
        k = 0;
        while (mq.size() > 0 && k < 64) begin
            idle();
            disp_ready = 1'b1;
            foreach (mq[i]) begin
                if (mq[i].st == ST_P) begin
                    commit(mq[i].id, ($urandom_range(1, 0) == 0));
                    break;
                end
            end
            cycle();
            k++;
        end
        idle();
        cycle();
        check("final_drained", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quadrilatero_xif_issue_buffer.md
Name: quadrilatero_xif_issue_buffer

Overview:
- Sits between the core's XIF issue/commit ports and the matrix dispatch logic.
- Forwards each issued instruction word to the combinational XIF decoder and returns the decoder's accept bit to the core.
- Buffers accepted instructions, with operands, in an in-order FIFO.
- Holds each entry until its commit or kill arrives, then dispatches it in order or drops it.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ID_W, 4, XIF instruction id width.
- X_RFR_W, 32, width of each scalar operand.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- x_issue_valid_i  in  1  core offers an instruction
- x_issue_ready_o  out  1  buffer can complete the issue handshake
- x_issue_instr_i  in  32  instruction word
- x_issue_id_i  in  ID_W  instruction id
- x_issue_rs1_i  in  X_RFR_W  operand rs1
- x_issue_rs2_i  in  X_RFR_W  operand rs2
- x_issue_rs_valid_i  in  2  per-operand valid bits
- x_issue_accept_o  out  1  accept bit returned to the core
- dec_instr_o  out  32  word driven to the decoder (equals x_issue_instr_i)
- dec_accept_i  in  1  decoder response accept field
- x_commit_valid_i  in  1  commit event
- x_commit_id_i  in  ID_W  id being committed
- x_commit_kill_i  in  1  commit event is a kill
- disp_valid_o  out  1  head entry ready to dispatch
- disp_ready_i  in  1  dispatch consumes the head
- disp_instr_o  out  32  head entry instruction word
- disp_rs1_o  out  X_RFR_W  head entry rs1
- disp_rs2_o  out  X_RFR_W  head entry rs2
- disp_id_o  out  ID_W  head entry id
- empty_o  out  1  no entries held
- unmatched_commit_o  out  1  one-cycle pulse when a commit matches no pending entry

Behaviour:
- Reset (async, active-high):
  - All entries invalid; read/write pointers and count = 0.
  - Outputs: x_issue_ready_o=0 while rst_i is high, disp_valid_o=0, empty_o=1, unmatched_commit_o=0.
  - Reset asserted mid-operation flushes every entry, including committed ones that were not yet dispatched.
- Issue handshake:
  - x_issue_ready_o = !full && (x_issue_rs_valid_i == 2'b11).
  - The handshake completes on the cycle where valid && ready.
  - x_issue_accept_o = dec_accept_i, combinational, same cycle, meaningful only while x_issue_valid_i.
- Enqueue:
  - On a completed handshake with dec_accept_i=1, write {instr, id, rs1, rs2} at the write pointer with state PENDING.
  - On a completed handshake with dec_accept_i=0, the handshake still completes and nothing is written.
- Entry states:
  - PENDING: waiting for commit.
  - COMMITTED: eligible for dispatch.
  - KILLED: to be dropped.
  - Invalid: free slot.
- Commit handling:
  - On x_commit_valid_i, every valid PENDING entry whose id equals x_commit_id_i moves to COMMITTED, or to KILLED if x_commit_kill_i=1.
  - If no entry matches, unmatched_commit_o pulses for one cycle and no state changes.
  - If the commit arrives in the same cycle as an enqueue with the same id, the new entry is written directly as COMMITTED or KILLED.
- Dispatch:
  - disp_valid_o = head valid && head COMMITTED. disp_* outputs are registered entry contents.
  - Pop on disp_valid_o && disp_ready_i.
  - A KILLED head is popped internally in one cycle with disp_valid_o=0.
  - A PENDING head blocks everything behind it, even entries that are already committed (strict in-order).
- Pointers wrap modulo DEPTH; count is (log2 DEPTH)+1 bits.
- Full and empty:
  - Full means count == DEPTH, so x_issue_ready_o=0.
  - A pop in the same cycle as an issue does not unblock ready in that cycle (ready depends on registered full only).
  - An enqueue and a pop in the same cycle leave count unchanged.
- Latency:
  - An issue whose commit arrives in the same cycle gives disp_valid_o=1 on the next cycle, provided the FIFO was empty.
  - A commit after the issue gives disp_valid_o=1 on the cycle after the commit.
- Protocol assumption: ids of outstanding entries are unique. Behaviour with duplicate ids is undefined and flagged by an assertion.

Test Plan:
- MLD_W word issued with id=3, rs_valid=11, dec_accept=1; commit id=3, kill=0 two cycles later -> x_issue_accept_o=1; disp_valid_o rises the cycle after the commit with disp_id_o=3 and rs1/rs2 echoed.
- Undecodable word with dec_accept=0 -> handshake completes with x_issue_accept_o=0; empty_o stays 1; a later commit of that id pulses unmatched_commit_o.
- Issue ids 1,2,3 with DEPTH=4; kill id 2; commit 1 and 3; disp_ready_i=1 -> dispatch order is 1 then 3; entry 2 never appears on disp_*.
- Issue 4 entries with no commits -> x_issue_ready_o=0 on the cycle after the 4th handshake; a 5th offer stalls. Commit the first entry and dispatch it -> ready returns to 1 one cycle later.
- Commit id=5 in the same cycle as its issue, FIFO empty -> disp_valid_o=1 on the next cycle.
- Two committed entries present, assert rst_i asynchronously mid-cycle -> disp_valid_o=0 and empty_o=1 immediately; nothing is dispatched after rst_i is released.
